// File: rtl/nfu3_stage_pipe.sv
// NFU-3 stage: per-lane piecewise-linear sigmoid (or bypass) over Tn lanes,
// three pipeline registers with a single shared stall enable.
module nfu3_stage_pipe #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned Tn        = 16,
  parameter int unsigned SEG_BITS  = 4,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [Tn*BIT_WIDTH-1:0]   i_inputs,
  input  logic                      i_bypass,
  input  logic                      i_coef_wr,
  input  logic [SEG_BITS-1:0]       i_coef_addr,
  input  logic [2*BIT_WIDTH-1:0]    i_sigmoid_coef,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [Tn*BIT_WIDTH-1:0]   o_outputs
);

  localparam int unsigned NUM_SEG = 1 << SEG_BITS;
  localparam int unsigned PW      = 2 * BIT_WIDTH;
  localparam int unsigned SW      = PW + 1;

  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  // Coefficient table shared by all lanes
  logic signed [BIT_WIDTH-1:0] r_coef_a [NUM_SEG];
  logic signed [BIT_WIDTH-1:0] r_coef_b [NUM_SEG];

  logic                        r_s1_valid;
  logic                        r_s1_bypass;
  logic signed [BIT_WIDTH-1:0] r_s1_x [Tn];
  logic signed [BIT_WIDTH-1:0] r_s1_a [Tn];
  logic signed [BIT_WIDTH-1:0] r_s1_b [Tn];

  logic                        r_s2_valid;
  logic                        r_s2_bypass;
  logic signed [BIT_WIDTH-1:0] r_s2_x    [Tn];
  logic signed [PW-1:0]        r_s2_prod [Tn];
  logic signed [BIT_WIDTH-1:0] r_s2_b    [Tn];

  logic                        w_stage_en;
  logic                        w_accept;
  logic signed [BIT_WIDTH-1:0] w_x   [Tn];
  logic [SEG_BITS-1:0]         w_seg [Tn];
  logic signed [SW-1:0]        w_sum [Tn];
  logic [BIT_WIDTH-1:0]        w_y   [Tn];
  logic [Tn*BIT_WIDTH-1:0]     w_y_flat;

  // Whole pipe moves only when the output register can be vacated
  assign w_stage_en = ~o_valid | i_ready;
  assign o_ready    = rst_n & w_stage_en & ~i_coef_wr;
  assign w_accept   = i_valid & o_ready;

  // Lane unpack and offset-binary segment index (most negative x -> 0)
  always_comb begin
    for (int k = 0; k < int'(Tn); k++) begin
      w_x[k]   = i_inputs[k*BIT_WIDTH +: BIT_WIDTH];
      w_seg[k] = {~w_x[k][BIT_WIDTH-1], w_x[k][BIT_WIDTH-2 -: SEG_BITS-1]};
    end
  end

  // Final add of B, saturation, bypass select
  always_comb begin
    w_y_flat = '0;
    for (int k = 0; k < int'(Tn); k++) begin
      w_sum[k] = (SW'(r_s2_prod[k]) >>> FRAC_BITS) + SW'(r_s2_b[k]);
      if (r_s2_bypass) begin
        w_y[k] = r_s2_x[k];
      end else if (w_sum[k] > SAT_MAX) begin
        w_y[k] = BIT_WIDTH'(SAT_MAX);
      end else if (w_sum[k] < SAT_MIN) begin
        w_y[k] = BIT_WIDTH'(SAT_MIN);
      end else begin
        w_y[k] = BIT_WIDTH'(w_sum[k]);
      end
      w_y_flat[k*BIT_WIDTH +: BIT_WIDTH] = w_y[k];
    end
  end

  // Table writes land independently of the pipeline stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SEG); i++) begin
        r_coef_a[i] <= '0;
        r_coef_b[i] <= '0;
      end
    end else if (i_coef_wr) begin
      r_coef_a[i_coef_addr] <= i_sigmoid_coef[PW-1 -: BIT_WIDTH];
      r_coef_b[i_coef_addr] <= i_sigmoid_coef[BIT_WIDTH-1:0];
    end
  end

  // S1 -> S2 -> S3 pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_bypass <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_bypass <= 1'b0;
      o_valid     <= 1'b0;
      o_outputs   <= '0;
      for (int k = 0; k < int'(Tn); k++) begin
        r_s1_x[k]    <= '0;
        r_s1_a[k]    <= '0;
        r_s1_b[k]    <= '0;
        r_s2_x[k]    <= '0;
        r_s2_prod[k] <= '0;
        r_s2_b[k]    <= '0;
      end
    end else if (w_stage_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_bypass <= i_bypass;
        for (int k = 0; k < int'(Tn); k++) begin
          r_s1_x[k] <= w_x[k];
          r_s1_a[k] <= r_coef_a[w_seg[k]];
          r_s1_b[k] <= r_coef_b[w_seg[k]];
        end
      end
      r_s2_valid  <= r_s1_valid;
      r_s2_bypass <= r_s1_bypass;
      for (int k = 0; k < int'(Tn); k++) begin
        r_s2_x[k]    <= r_s1_x[k];
        r_s2_prod[k] <= PW'(r_s1_a[k]) * PW'(r_s1_x[k]);
        r_s2_b[k]    <= r_s1_b[k];
      end
      o_valid <= r_s2_valid;
      if (r_s2_valid) begin
        o_outputs <= w_y_flat;
      end
    end
  end

endmodule

// File: tb/tb_nfu3_stage_pipe.sv
// Scoreboard bench for nfu3_stage_pipe: directed scenarios then random traffic
// against an arithmetic reference of the segment lookup and saturating line.
module tb_nfu3_stage_pipe;

  localparam int TN = 4;
  localparam int BW = 16;
  localparam int VW = TN * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [VW-1:0] i_inputs = '0;
  logic          i_bypass = 1'b0;
  logic          i_coef_wr = 1'b0;
  logic [3:0]    i_coef_addr = '0;
  logic [31:0]   i_sigmoid_coef = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [VW-1:0] o_outputs;

  nfu3_stage_pipe #(.BIT_WIDTH(BW), .Tn(TN), .SEG_BITS(4), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inputs(i_inputs), .i_bypass(i_bypass), .i_coef_wr(i_coef_wr),
    .i_coef_addr(i_coef_addr), .i_sigmoid_coef(i_sigmoid_coef),
    .o_valid(o_valid), .i_ready(i_ready), .o_outputs(o_outputs)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_out    = 0;
  int            ref_a [16];
  int            ref_b [16];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] last_out = '0;
  logic [VW-1:0] hold_val = '0;
  bit            hold_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: top SEG bits of offset-binary x pick the entry, then floor(A*x/256)+B clamped
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input bit byp);
    int xs, seg;
    longint p;
    if (byp) return x;
    xs  = int'($signed(x));
    seg = (xs + 32768) / 4096;
    p   = (longint'(ref_a[seg]) * longint'(xs)) >>> 8;
    p   = p + longint'(ref_b[seg]);
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic logic [VW-1:0] ref_beat(input logic [VW-1:0] v, input bit byp);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < TN; k++) r[k*BW +: BW] = ref_lane(v[k*BW +: BW], byp);
    return r;
  endfunction

  // Monitor/scoreboard: everything here is stable between the driving edge+1 and the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
      for (int i = 0; i < 16; i++) begin ref_a[i] = 0; ref_b[i] = 0; end
    end else begin
      if (hold_pending && o_valid) chk("hold_stable", 64'(o_outputs), 64'(hold_val));
      hold_pending = 1'b0;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h expected none at %0t", o_outputs, $time);
        end else begin
          chk("scoreboard", 64'(o_outputs), 64'(exp_q.pop_front()));
        end
        n_out++;
        last_out = o_outputs;
      end else if (o_valid) begin
        hold_pending = 1'b1;
        hold_val = o_outputs;
      end
      if (i_valid && o_ready) exp_q.push_back(ref_beat(i_inputs, i_bypass));
      if (i_coef_wr) begin
        ref_a[i_coef_addr] = int'($signed(i_sigmoid_coef[31:16]));
        ref_b[i_coef_addr] = int'($signed(i_sigmoid_coef[15:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; i_valid = 1'b0; i_coef_wr = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 64'(o_ready), 64'd0);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_outputs", 64'(o_outputs), 64'd0);
    step();
  endtask

  task automatic write_coef(input int addr, input logic [15:0] a, input logic [15:0] b);
    i_coef_wr = 1'b1; i_coef_addr = 4'(addr); i_sigmoid_coef = {a, b};
    step();
    i_coef_wr = 1'b0;
  endtask

  task automatic load_identity();
    for (int i = 0; i < 16; i++) write_coef(i, 16'h0100, 16'h0000);
  endtask

  // Holds i_valid until the beat is taken; leaves i_valid asserted for back-to-back use
  task automatic send(input logic [VW-1:0] v, input bit byp);
    bit acc;
    int budget;
    budget = 0;
    i_valid = 1'b1; i_inputs = v; i_bypass = byp;
    do begin
      @(negedge clk);
      acc = o_ready;
      step();
      budget++;
    end while (!acc && budget < 200);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 200 cycles");
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [15:0] x);
    return {TN{x}};
  endfunction

  initial begin
    int base;
    logic [VW-1:0] v;

    reset_dut();

    // Identity and exact three-edge latency
    load_identity();
    send(splat(16'h0123), 1'b0);
    i_valid = 1'b0;
    @(negedge clk); chk("lat_after_1", 64'(o_valid), 64'd0);
    step();
    @(negedge clk); chk("lat_after_2", 64'(o_valid), 64'd0);
    step();
    @(negedge clk);
    chk("lat_after_3", 64'(o_valid), 64'd1);
    chk("identity_lane", 64'(o_outputs[15:0]), 64'h0123);
    idle(3);

    // Saturation at both rails
    write_coef(15, 16'h7FFF, 16'h7FFF);
    write_coef(0, 16'h7FFF, 16'h8000);
    send({16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}, 1'b0);
    idle(6);
    chk("sat_high", 64'(last_out[15:0]), 64'h7FFF);
    chk("sat_low", 64'(last_out[31:16]), 64'h8000);

    // Bypass vs sigmoid with an all-zero table
    reset_dut();
    send(splat(16'h8001), 1'b1);
    idle(6);
    chk("bypass_value", 64'(last_out), 64'(splat(16'h8001)));
    send(splat(16'h8001), 1'b0);
    idle(6);
    chk("sigmoid_zero_table", 64'(last_out), 64'd0);

    // Back-to-back 1..6 with a 5-cycle output stall mid-stream
    load_identity();
    base = n_out;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(splat(16'(i)), 1'b0);
        i_valid = 1'b0;
      end
      begin
        step(); step(); step();
        i_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("ready_in_stall", 64'(o_ready), 64'd0);
          step();
        end
        i_ready = 1'b1;
      end
    join
    idle(8);
    chk("stall_count", 64'(n_out - base), 64'd6);
    chk("stall_last", 64'(last_out[15:0]), 64'd6);

    // Coefficient write blocks acceptance; next beat sees the new entry
    base = n_out;
    i_inputs = splat(16'h0100); i_bypass = 1'b0; i_valid = 1'b1;
    i_coef_wr = 1'b1; i_coef_addr = 4'd8; i_sigmoid_coef = {16'h0200, 16'h0010};
    @(negedge clk); chk("ready_during_wr", 64'(o_ready), 64'd0);
    step();
    i_coef_wr = 1'b0;
    @(negedge clk); chk("ready_after_wr", 64'(o_ready), 64'd1);
    step();
    idle(6);
    chk("wr_beat_count", 64'(n_out - base), 64'd1);
    chk("wr_new_entry", 64'(last_out[15:0]), 64'h0210);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) send(splat(16'(16'h0040 + i)), 1'b0);
    i_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_o_valid", 64'(o_valid), 64'd0);
    chk("midreset_o_outputs", 64'(o_outputs), 64'd0);
    base = n_out;
    idle(4);
    chk("midreset_no_leak", 64'(n_out - base), 64'd0);
    send(splat(16'h0123), 1'b0);
    idle(6);
    chk("midreset_table_zero", 64'(last_out), 64'd0);

    // Random traffic with random table contents, stalls and writes
    for (int i = 0; i < 16; i++)
      write_coef(i, ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)),
                 16'($urandom));
    repeat (600) begin
      for (int k = 0; k < TN; k++) v[k*BW +: BW] = 16'($urandom);
      i_inputs       = v;
      i_valid        = ($urandom_range(0, 3) != 0);
      i_bypass       = ($urandom_range(0, 3) == 0);
      i_coef_wr      = ($urandom_range(0, 15) == 0);
      i_coef_addr    = 4'($urandom);
      i_sigmoid_coef = $urandom;
      i_ready        = ($urandom_range(0, 3) != 0);
      step();
    end
    i_coef_wr = 1'b0; i_ready = 1'b1;
    idle(10);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/nfu3_stage_pipe.md
NFU3_STAGE_PIPE -- requirements
Module: nfu3_stage_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16: width of one neuron value (signed two's complement).
REQ-002 SHALL have parameter Tn, default 16: number of neuron lanes per beat.
REQ-003 SHALL have parameter SEG_BITS, default 4: log2 of sigmoid segment count (NUM_SEG = 2^SEG_BITS).
REQ-004 SHALL have parameter FRAC_BITS, default 8: fractional bits of coefficient A.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port i_valid  input  1  input beat valid.
REQ-008 SHALL have port o_ready  output  1  stage can accept an input beat.
REQ-009 SHALL have port i_inputs  input  Tn*BIT_WIDTH  NFU-2 partial sums; lane k = bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SHALL have port i_bypass  input  1  per-beat mode: 1 = forward partial sum unchanged to NBout, 0 = apply sigmoid.
REQ-011 SHALL have port i_coef_wr  input  1  coefficient table write strobe.
REQ-012 SHALL have port i_coef_addr  input  SEG_BITS  coefficient table entry index.
REQ-013 SHALL have port i_sigmoid_coef  input  2*BIT_WIDTH  {A (upper half), B (lower half)}, both signed.
REQ-014 SHALL have port o_valid  output  1  output beat valid.
REQ-015 SHALL have port i_ready  input  1  NBout can accept the output beat.
REQ-016 SHALL have port o_outputs  output  Tn*BIT_WIDTH  results to NBout, same lane packing as i_inputs.

Function
REQ-017 SHALL hold a NUM_SEG-entry coefficient table shared by all lanes; when i_coef_wr=1 on a rising edge, entry i_coef_addr SHALL take i_sigmoid_coef.
REQ-018 SHALL drive o_ready = stage_en AND NOT i_coef_wr, where stage_en = NOT o_valid OR i_ready.
REQ-019 SHALL accept a beat exactly when i_valid=1 and o_ready=1; i_inputs and i_bypass SHALL be ignored otherwise.
REQ-020 SHALL be a 3-stage pipeline: S1 registers lanes, bypass flag and per-lane table lookup; S2 registers signed product A*x at full 2*BIT_WIDTH width; S3 registers add/saturate result and drives o_outputs, o_valid.
REQ-021 SHALL advance all stages together only when stage_en=1; when stage_en=0, all stage contents including o_outputs and o_valid SHALL hold.
REQ-022 SHALL, with no stall, present an accepted beat on o_outputs with o_valid=1 exactly 3 cycles after acceptance; beats SHALL leave in acceptance order with no loss or duplication.
REQ-023 SHALL insert a bubble (valid=0) into S1 on any advancing cycle with no accepted beat.
REQ-024 SHALL select the segment per lane as index = {NOT x[BIT_WIDTH-1], x[BIT_WIDTH-2 -: SEG_BITS-1]} (offset binary; most negative x -> 0).
REQ-025 SHALL compute y = saturate(((A*x) >>> FRAC_BITS) + sign-extended B) to the signed BIT_WIDTH range [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
REQ-026 SHALL, for bypass beats, output x unchanged on every lane with the same 3-cycle latency, interleaving freely with sigmoid beats.
REQ-027 SHALL make a table write visible to beats whose S1 lookup occurs on a later edge; beats already in S1-S3 SHALL use the values they looked up.
REQ-028 SHALL complete o_valid=1 beat transfer when i_ready=1 on that edge; o_outputs SHALL stay stable while o_valid=1 and i_ready=0.

Reset
REQ-029 SHALL, on a rising edge with rst_n=0, clear all stage valid bits, o_valid, o_outputs, bypass flags and every coefficient table entry to 0, discarding in-flight beats.
REQ-030 SHALL drive o_ready=0 while rst_n=0 and allow acceptance from the first edge after rst_n returns to 1.

Verification
REQ-031 SHALL verify identity: all entries A=0x0100, B=0x0000; lane x=0x0123 accepted -> o_outputs lane 0x0123, o_valid=1 exactly 3 cycles later.
REQ-032 SHALL verify saturation: entry 15 A=0x7FFF, B=0x7FFF; x=0x7FFF -> 0x7FFF; entry 0 A=0x7FFF, B=0x8000; x=0x8000 -> 0x8000.
REQ-033 SHALL verify bypass: i_bypass=1, x=0x8001 with all-zero table -> 0x8001 after 3 cycles; next beat i_bypass=0 same x -> 0x0000.
REQ-034 SHALL verify backpressure: 6 back-to-back beats values 1..6, i_ready=0 for 5 cycles mid-stream -> o_ready=0 during stall, outputs 1..6 in order, none dropped or repeated.
REQ-035 SHALL verify coefficient write: i_coef_wr=1 with i_valid=1 -> o_ready=0, beat not accepted; beat accepted next cycle uses new entry.
REQ-036 SHALL verify reset mid-operation: rst_n=0 one cycle with 3 beats in flight -> o_valid=0, o_outputs=0, table reads 0 (identity beat yields B=0 result 0x0000).
